// File: rtl/mem_skew_pkg.sv
// Shared types and the skew lane-selection helper for the ping-pong operand memory.
package mem_skew_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    typedef struct packed {
        logic        vld;
        logic [31:0] idx;
    } skew_t;

    // Lane i carries element index t-i when it falls inside the matrix, else the lane is empty.
    function automatic skew_t skew_sel(input int t, input int i, input int dim);
        skew_t r;
        r.vld = 1'b0;
        r.idx = 32'd0;
        if ((t >= i) && ((t - i) < dim)) begin
            r.vld = 1'b1;
            r.idx = 32'(t - i);
        end else begin
            r.vld = 1'b0;
            r.idx = 32'd0;
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_bank.sv
// One DIM x DIM operand bank: single row-write port, DIM independent combinational element reads.
module mem_bank
    import mem_skew_pkg::*;
#(
    parameter  int BITS_AB = 8,
    parameter  int DIM     = 8,
    localparam int AW      = $clog2(DIM)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      we,
    input  logic [AW-1:0]             wrow,
    input  logic signed [BITS_AB-1:0] wdata [DIM],
    input  logic [AW-1:0]             rrow  [DIM],
    input  logic [AW-1:0]             rcol  [DIM],
    output logic signed [BITS_AB-1:0] rdata [DIM]
);

    logic signed [BITS_AB-1:0] mem_q [DIM][DIM];
    logic signed [BITS_AB-1:0] mem_d [DIM][DIM];

    // Row write: a whole row is replaced at once, other rows keep their contents.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[wrow] = wdata;
        end else begin
            mem_d = mem_q;
        end
    end

    // Storage register, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < DIM; r++) begin
                for (int c = 0; c < DIM; c++) begin
                    mem_q[r][c] <= '0;
                end
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Per-lane element read.
    always_comb begin
        for (int i = 0; i < DIM; i++) begin
            rdata[i] = mem_q[rrow[i]][rcol[i]];
        end
    end

endmodule

// File: rtl/mem_skew_pp.sv
// Ping-pong operand memory: rows are loaded into one bank while the other streams to the
// systolic array with lane i delayed by i beats, optionally transposed.
module mem_skew_pp
    import mem_skew_pkg::*;
#(
    parameter  int BITS_AB = 8,
    parameter  int DIM     = 8,
    localparam int CW      = $clog2(2*DIM),
    localparam int AW      = $clog2(DIM)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [AW-1:0]             wr_row,
    input  logic signed [BITS_AB-1:0] wr_data [DIM],
    input  logic                      wr_commit,
    output logic                      wr_ready,
    input  logic                      rd_start,
    input  logic                      transpose,
    input  logic                      en,
    output logic signed [BITS_AB-1:0] Aout [DIM],
    output logic                      out_valid,
    output logic                      out_last,
    output logic                      rd_busy,
    output logic [1:0]                bank_full
);

    localparam logic [CW-1:0] LAST_T = CW'(2*DIM-2);

    state_t                    state_q, state_d;
    logic                      wr_ptr_q, wr_ptr_d;
    logic                      rd_ptr_q, rd_ptr_d;
    logic [1:0]                bank_full_q, bank_full_d;
    logic                      wr_ready_q, wr_ready_d;
    logic [CW-1:0]             t_q, t_d;
    logic                      tr_q, tr_d;
    logic signed [BITS_AB-1:0] aout_q [DIM];
    logic signed [BITS_AB-1:0] aout_d [DIM];
    logic                      out_valid_q, out_valid_d;
    logic                      out_last_q, out_last_d;
    logic                      rd_busy_q, rd_busy_d;

    logic                      wr_acc_s;
    logic                      commit_acc_s;
    logic [1:0]                bank_we_s;
    skew_t                     sel_s   [DIM];
    logic [AW-1:0]             rrow_s  [DIM];
    logic [AW-1:0]             rcol_s  [DIM];
    logic signed [BITS_AB-1:0] rdata0_s [DIM];
    logic signed [BITS_AB-1:0] rdata1_s [DIM];
    logic signed [BITS_AB-1:0] lane_s  [DIM];

    // Write acceptance uses the registered ready so a freshly released bank opens one cycle later.
    always_comb begin
        wr_acc_s     = wr_en && wr_ready_q;
        commit_acc_s = wr_commit && wr_ready_q;
        bank_we_s    = 2'b00;
        if (wr_acc_s) begin
            bank_we_s[wr_ptr_q] = 1'b1;
        end else begin
            bank_we_s = 2'b00;
        end
    end

    mem_bank #(.BITS_AB(BITS_AB), .DIM(DIM)) u_bank0 (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (bank_we_s[0]),
        .wrow  (wr_row),
        .wdata (wr_data),
        .rrow  (rrow_s),
        .rcol  (rcol_s),
        .rdata (rdata0_s)
    );

    mem_bank #(.BITS_AB(BITS_AB), .DIM(DIM)) u_bank1 (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (bank_we_s[1]),
        .wrow  (wr_row),
        .wdata (wr_data),
        .rrow  (rrow_s),
        .rcol  (rcol_s),
        .rdata (rdata1_s)
    );

    // Beat t, lane i reads E(i, t-i); transpose swaps the row/column roles.
    always_comb begin
        for (int i = 0; i < DIM; i++) begin
            sel_s[i] = skew_sel(int'(t_q), i, DIM);
            if (tr_q) begin
                rrow_s[i] = AW'(sel_s[i].idx);
                rcol_s[i] = AW'(i);
            end else begin
                rrow_s[i] = AW'(i);
                rcol_s[i] = AW'(sel_s[i].idx);
            end
            if (sel_s[i].vld && (sel_s[i].idx < 32'(DIM))) begin
                lane_s[i] = rd_ptr_q ? rdata1_s[i] : rdata0_s[i];
            end else begin
                lane_s[i] = '0;
            end
        end
    end

    // Pointer, full-flag and stream FSM next state.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        bank_full_d = bank_full_q;
        t_d         = t_q;
        tr_d        = tr_q;
        aout_d      = aout_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        rd_busy_d   = rd_busy_q;

        if (commit_acc_s) begin
            bank_full_d[wr_ptr_q] = 1'b1;
            wr_ptr_d              = ~wr_ptr_q;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        case (state_q)
            IDLE: begin
                if (rd_start && bank_full_q[rd_ptr_q]) begin
                    state_d   = STREAM;
                    tr_d      = transpose;
                    t_d       = '0;
                    rd_busy_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            STREAM: begin
                if (en) begin
                    if (out_last_q) begin
                        // Final beat has been consumed: hand the bank back to the writer.
                        state_d               = IDLE;
                        bank_full_d[rd_ptr_q] = 1'b0;
                        rd_ptr_d              = ~rd_ptr_q;
                        for (int i = 0; i < DIM; i++) begin
                            aout_d[i] = '0;
                        end
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        rd_busy_d   = 1'b0;
                    end else begin
                        aout_d      = lane_s;
                        out_valid_d = 1'b1;
                        out_last_d  = (t_q == LAST_T);
                        t_d         = t_q + CW'(1);
                    end
                end else begin
                    state_d = STREAM;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        wr_ready_d = ~bank_full_d[wr_ptr_d];
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            bank_full_q <= 2'b00;
            wr_ready_q  <= 1'b1;
            t_q         <= '0;
            tr_q        <= 1'b0;
            for (int i = 0; i < DIM; i++) begin
                aout_q[i] <= '0;
            end
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            rd_busy_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            bank_full_q <= bank_full_d;
            wr_ready_q  <= wr_ready_d;
            t_q         <= t_d;
            tr_q        <= tr_d;
            aout_q      <= aout_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            rd_busy_q   <= rd_busy_d;
        end
    end

    assign wr_ready  = wr_ready_q;
    assign Aout      = aout_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign rd_busy   = rd_busy_q;
    assign bank_full = bank_full_q;

endmodule

// File: tb/tb_mem_skew_pp.sv
// Directed bench for mem_skew_pp (DIM=4, BITS_AB=8) with a reference model feeding a beat scoreboard.
module tb_mem_skew_pp;

    localparam int DIM = 4;
    localparam int NB  = 2*DIM-1;

    logic              clk;
    logic              rst_n;
    logic              wr_en;
    logic [1:0]        wr_row;
    logic signed [7:0] wr_data [DIM];
    logic              wr_commit;
    logic              wr_ready;
    logic              rd_start;
    logic              transpose;
    logic              en;
    logic signed [7:0] Aout [DIM];
    logic              out_valid;
    logic              out_last;
    logic              rd_busy;
    logic [1:0]        bank_full;

    mem_skew_pp #(.BITS_AB(8), .DIM(DIM)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_row    (wr_row),
        .wr_data   (wr_data),
        .wr_commit (wr_commit),
        .wr_ready  (wr_ready),
        .rd_start  (rd_start),
        .transpose (transpose),
        .en        (en),
        .Aout      (Aout),
        .out_valid (out_valid),
        .out_last  (out_last),
        .rd_busy   (rd_busy),
        .bank_full (bank_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic             last;
        logic [3:0][7:0]  l;
    } beat_t;

    int              checks   = 0;
    int              failures = 0;
    beat_t           q[$];
    beat_t           exp_beats [NB];
    logic [3:0][7:0] obs_beats [NB];
    int              beat_idx;
    int              cyc;
    logic [7:0]      mat [2][DIM][DIM];
    bit              mfull [2];
    int              mwp;
    int              mrp;
    logic [3:0][7:0] row_v;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp_v));
        end
    endtask

    // One clock; any beat registered on this edge is popped from the scoreboard and compared.
    task automatic tick();
        logic  en_s;
        beat_t e;
        en_s = en;
        @(posedge clk);
        #1;
        cyc++;
        if (en_s && out_valid) begin
            checks++;
            assert (q.size() != 0) else begin
                failures++;
                $error("FAIL sb_extra_beat observed=%0d expected=%0d", 1, 0);
            end
            if (q.size() != 0) begin
                e = q.pop_front();
                for (int i = 0; i < DIM; i++) begin
                    chk($sformatf("beat%0d_lane%0d", beat_idx, i), Aout[i], $signed(e.l[i]));
                    if (beat_idx < NB) obs_beats[beat_idx][i] = Aout[i];
                end
                chk($sformatf("beat%0d_last", beat_idx), out_last, e.last);
                beat_idx++;
            end
        end
    endtask

    function automatic logic [3:0][7:0] mk_row(input int r, input int base);
        logic [3:0][7:0] v;
        for (int c = 0; c < DIM; c++) v[c] = 8'(r*DIM + c + base);
        return v;
    endfunction

    task automatic wr(input int row, input logic [3:0][7:0] vals, input logic cm);
        wr_en     = 1'b1;
        wr_row    = 2'(row);
        wr_commit = cm;
        for (int j = 0; j < DIM; j++) wr_data[j] = vals[j];
        if (!mfull[mwp]) begin
            for (int j = 0; j < DIM; j++) mat[mwp][row][j] = vals[j];
            if (cm) begin
                mfull[mwp] = 1'b1;
                mwp        = 1 - mwp;
            end
        end
        tick();
        wr_en     = 1'b0;
        wr_commit = 1'b0;
    endtask

    task automatic push_expected(input int b, input logic tr);
        beat_t e;
        for (int t = 0; t < NB; t++) begin
            for (int i = 0; i < DIM; i++) begin
                int k;
                k = t - i;
                if (k >= 0 && k < DIM) e.l[i] = tr ? mat[b][k][i] : mat[b][i][k];
                else                   e.l[i] = 8'd0;
            end
            e.last       = (t == NB-1);
            exp_beats[t] = e;
            q.push_back(e);
        end
        beat_idx = 0;
    endtask

    task automatic start_stream(input logic tr);
        push_expected(mrp, tr);
        transpose = tr;
        en        = 1'b1;
        rd_start  = 1'b1;
        cyc       = 0;
        tick();
        rd_start  = 1'b0;
        chk("rd_busy_on", rd_busy, 1);
    endtask

    task automatic finish_stream(input int stall_beat);
        bit stalled;
        stalled = 1'b0;
        while (rd_busy && cyc < 60) begin
            if (stall_beat >= 0 && !stalled && beat_idx == stall_beat+1) begin
                en = 1'b0;
                repeat (3) begin
                    tick();
                    for (int i = 0; i < DIM; i++)
                        chk("stall_hold", Aout[i], $signed(exp_beats[stall_beat].l[i]));
                    chk("stall_valid", out_valid, 1);
                end
                en      = 1'b1;
                stalled = 1'b1;
            end
            tick();
        end
        chk("stream_end_busy", rd_busy, 0);
        chk("stream_end_valid", out_valid, 0);
        chk("beats_seen", beat_idx, NB);
        chk("sb_empty", q.size(), 0);
        mfull[mrp] = 1'b0;
        mrp        = 1 - mrp;
    endtask

    initial begin
        rst_n     = 1'b0;
        wr_en     = 1'b0;
        wr_row    = 2'd0;
        wr_commit = 1'b0;
        rd_start  = 1'b0;
        transpose = 1'b0;
        en        = 1'b0;
        for (int j = 0; j < DIM; j++) wr_data[j] = 8'sd0;
        for (int b = 0; b < 2; b++) begin
            mfull[b] = 1'b0;
            for (int r = 0; r < DIM; r++)
                for (int c = 0; c < DIM; c++) mat[b][r][c] = 8'd0;
        end
        mwp = 0;
        mrp = 0;
        cyc = 0;

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < DIM; i++) chk("rst_aout", Aout[i], 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_busy", rd_busy, 0);
        chk("rst_full", bank_full, 2'b00);
        chk("rst_ready", wr_ready, 1);
        #2 rst_n = 1'b1;

        // rd_start with nothing committed is ignored.
        en       = 1'b1;
        rd_start = 1'b1;
        tick();
        tick();
        rd_start = 1'b0;
        chk("empty_start_valid", out_valid, 0);
        chk("empty_start_busy", rd_busy, 0);

        // Plain skewed stream of M[r][c] = r*4+c.
        for (int r = 0; r < DIM; r++) wr(r, mk_row(r, 0), r == DIM-1);
        chk("full_after_c0", bank_full, 2'b01);
        chk("ready_after_c0", wr_ready, 1);
        start_stream(1'b0);
        finish_stream(-1);
        chk("cycles_plain", cyc, 9);
        chk("b0_l0", $signed(obs_beats[0][0]), 0);
        chk("b1_l0", $signed(obs_beats[1][0]), 1);
        chk("b1_l1", $signed(obs_beats[1][1]), 4);
        chk("b3_l0", $signed(obs_beats[3][0]), 3);
        chk("b3_l1", $signed(obs_beats[3][1]), 6);
        chk("b3_l2", $signed(obs_beats[3][2]), 9);
        chk("b3_l3", $signed(obs_beats[3][3]), 12);
        chk("b6_l3", $signed(obs_beats[6][3]), 15);
        chk("b6_l0", $signed(obs_beats[6][0]), 0);

        // Transposed stream of the same matrix from bank 1.
        for (int r = DIM-1; r >= 0; r--) wr(r, mk_row(r, 0), r == 0);
        chk("full_after_c1", bank_full, 2'b10);
        start_stream(1'b1);
        finish_stream(-1);
        chk("tb3_l0", $signed(obs_beats[3][0]), 12);
        chk("tb3_l1", $signed(obs_beats[3][1]), 9);
        chk("tb3_l2", $signed(obs_beats[3][2]), 6);
        chk("tb3_l3", $signed(obs_beats[3][3]), 3);

        // Ping-pong: load bank 1 while bank 0 streams, with extreme signed values in bank 0.
        for (int r = 0; r < DIM; r++) begin
            row_v = mk_row(r, 0);
            if (r == 0)     row_v[0] = 8'h80;
            if (r == DIM-1) row_v[3] = 8'h7f;
            wr(r, row_v, r == DIM-1);
        end
        start_stream(1'b0);
        for (int r = 0; r < DIM; r++) wr(r, mk_row(r, 100), r == DIM-1);
        chk("pp_full_both", bank_full, 2'b11);
        chk("pp_ready_low", wr_ready, 0);
        for (int j = 0; j < DIM; j++) row_v[j] = 8'h80;
        wr(0, row_v, 1'b1);
        chk("pp_third_commit", bank_full, 2'b11);
        finish_stream(-1);
        chk("pp_signed_min", $signed(obs_beats[0][0]), -128);
        chk("pp_signed_max", $signed(obs_beats[6][3]), 127);
        chk("pp_full_after", bank_full, 2'b10);
        chk("pp_ready_after", wr_ready, 1);

        // Stream the +100 bank with a 3-cycle stall after beat 2.
        start_stream(1'b0);
        finish_stream(2);
        chk("cycles_stall", cyc, 12);
        chk("drop_kept_row0", $signed(obs_beats[0][0]), 100);
        chk("full_all_free", bank_full, 2'b00);

        // Reset in the middle of a stream.
        for (int r = 0; r < DIM; r++) wr(r, mk_row(r, 20), r == DIM-1);
        start_stream(1'b0);
        while (beat_idx < 4 && cyc < 30) tick();
        chk("pre_reset_beat", beat_idx, 4);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < DIM; i++) chk("mid_rst_aout", Aout[i], 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_full", bank_full, 2'b00);
        chk("mid_rst_ready", wr_ready, 1);
        q.delete();
        for (int b = 0; b < 2; b++) begin
            mfull[b] = 1'b0;
            for (int r = 0; r < DIM; r++)
                for (int c = 0; c < DIM; c++) mat[b][r][c] = 8'd0;
        end
        mwp = 0;
        mrp = 0;
        @(posedge clk);
        #3 rst_n = 1'b1;

        // Fresh load after reset, rows written out of order.
        wr(2, mk_row(2, 40), 1'b0);
        wr(0, mk_row(0, 40), 1'b0);
        wr(3, mk_row(3, 40), 1'b0);
        wr(1, mk_row(1, 40), 1'b1);
        chk("post_rst_full", bank_full, 2'b01);
        start_stream(1'b0);
        finish_stream(-1);
        chk("post_rst_cycles", cyc, 9);
        chk("post_rst_b3_l1", $signed(obs_beats[3][1]), 46);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
